// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, sequences exception/eret flushes, watches for runaway stalls.
// Optional perf counters (stall_cycles, flush_count) are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [31:0] ERET_TYPE = 32'h0000000e;

  state_t      state_q, state_d;
  logic [31:0] epc_q;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
  logic        exc_det;
  logic [31:0] exc_target;
  logic [5:0]  stall_req;

  // An exception waits until the data bus transfer finishes.
  assign exc_det    = (state_q == RUN) && (excepttype_i != 32'h0) && !stallreq_from_mem;
  assign exc_target = (excepttype_i == ERET_TYPE) ? cp0_epc_i : EXC_VECTOR;

  always_comb begin
    stall_req = 6'b000000;
    if (exc_det || stallreq_from_mem) begin
      stall_req = 6'b011111;
    end else if (stallreq_from_ex) begin
      stall_req = 6'b001111;
    end else if (stallreq_from_id || stallreq_from_if) begin
      stall_req = 6'b000111;
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = 32'h0;
    case (state_q)
      RUN: begin
        stall = stall_req;
        if (exc_det) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        new_pc  = epc_q;
        state_d = SETTLE;
      end
      SETTLE: begin
        stall   = stall_req;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Hold everything quiet while reset is asserted, even if requests are up.
    if (!rst) begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'h0;
    end
  end

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_q == FLUSH || stall == 6'b000000) begin
      wd_cnt_d = 16'd0;
    end else begin
      if (wd_cnt_q != TIMEOUT) begin
        wd_cnt_d = wd_cnt_q + 16'd1;
      end
      if (wd_cnt_q == TIMEOUT - 16'd1) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      epc_q     <= 32'h0;
      wd_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      if (exc_det) begin
        epc_q <= exc_target;
      end
    end
  end

  assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 32'h0;
    end else begin
      if (stall[0]) begin
        stall_cycles_q <= stall_cycles_q + 32'h1;
      end
      if (state_q == FLUSH) begin
        flush_count_q <= flush_count_q + 32'h1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (TIMEOUT overridden to 8); perf expectations follow PIPE_CTRL_PERF_EN.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_from_if = 1'b0;
  logic        stallreq_from_id = 1'b0;
  logic        stallreq_from_ex = 1'b0;
  logic        stallreq_from_mem = 1'b0;
  logic [31:0] excepttype_i = 32'h0;
  logic [31:0] cp0_epc_i = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int checks = 0;
  int failures = 0;

  pipe_ctrl #(.EXC_VECTOR(32'h00000020), .TIMEOUT(16'd8)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .excepttype_i      (excepttype_i),
    .cp0_epc_i         (cp0_epc_i),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_timeout     (stall_timeout),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_from_if  = 1'b0;
    stallreq_from_id  = 1'b0;
    stallreq_from_ex  = 1'b0;
    stallreq_from_mem = 1'b0;
    excepttype_i      = 32'h0;
    cp0_epc_i         = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    #3 rst = 1'b0;
    #12 rst = 1'b1;
    next();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL reset_stall got=%b exp=000000", stall); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (new_pc !== 32'h0) begin failures++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout); end
    checks++; if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin failures++; $display("FAIL reset_perf got=%h/%h exp=0/0", stall_cycles, flush_count); end
  endtask

  task automatic test_priority();
    do_reset();
    stallreq_from_ex = 1'b1; stallreq_from_id = 1'b1; #1;
    checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL ex_id_stall got=%b exp=001111", stall); end
    next(); clear_inputs(); #1;
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL drop_stall got=%b exp=000000", stall); end
    next(); stallreq_from_if = 1'b1; #1;
    checks++; if (stall !== 6'b000111) begin failures++; $display("FAIL if_stall got=%b exp=000111", stall); end
    next(); clear_inputs(); stallreq_from_id = 1'b1; #1;
    checks++; if (stall !== 6'b000111) begin failures++; $display("FAIL id_stall got=%b exp=000111", stall); end
    next(); clear_inputs(); stallreq_from_mem = 1'b1; stallreq_from_ex = 1'b1; #1;
    checks++; if (stall !== 6'b011111) begin failures++; $display("FAIL mem_ex_stall got=%b exp=011111", stall); end
    next(); clear_inputs(); #1;
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL idle_stall got=%b exp=000000", stall); end
  endtask

  task automatic test_exc_bus_wait();
    do_reset();
    excepttype_i = 32'h00000008; stallreq_from_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 6'b011111 || flush !== 1'b0) begin failures++; $display("FAIL buswait_%0d stall=%b flush=%b exp=011111/0", i, stall, flush); end
      next();
    end
    stallreq_from_mem = 1'b0; #1;
    checks++; if (stall !== 6'b011111 || flush !== 1'b0) begin failures++; $display("FAIL excdet stall=%b flush=%b exp=011111/0", stall, flush); end
    next(); excepttype_i = 32'h0; stallreq_from_ex = 1'b1; #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h00000020) begin failures++; $display("FAIL exc_flush flush=%b pc=%h exp=1/00000020", flush, new_pc); end
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL flush_stall got=%b exp=000000", stall); end
    next(); #1;
    checks++; if (flush !== 1'b0 || new_pc !== 32'h0) begin failures++; $display("FAIL settle flush=%b pc=%h exp=0/0", flush, new_pc); end
    checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL settle_stall got=%b exp=001111", stall); end
    next(); clear_inputs();
  endtask

  task automatic test_eret();
    do_reset();
    excepttype_i = 32'h0000000e; cp0_epc_i = 32'hBFC00100; stallreq_from_id = 1'b1; #1;
    checks++; if (stall !== 6'b011111) begin failures++; $display("FAIL eret_det_stall got=%b exp=011111", stall); end
    next(); clear_inputs(); #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'hBFC00100) begin failures++; $display("FAIL eret_flush flush=%b pc=%h exp=1/bfc00100", flush, new_pc); end
    next(); excepttype_i = 32'h00000008; #1;
    checks++; if (stall !== 6'b000000 || flush !== 1'b0) begin failures++; $display("FAIL settle_masked stall=%b flush=%b exp=000000/0", stall, flush); end
    next(); #1;
    checks++; if (stall !== 6'b011111 || flush !== 1'b0) begin failures++; $display("FAIL retake_det stall=%b flush=%b exp=011111/0", stall, flush); end
    next(); clear_inputs(); #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h00000020) begin failures++; $display("FAIL retake_flush flush=%b pc=%h exp=1/00000020", flush, new_pc); end
    next(); next();
  endtask

  task automatic test_watchdog();
    do_reset();
    stallreq_from_ex = 1'b1;
    for (int i = 0; i < 7; i++) next();
    stallreq_from_ex = 1'b0; #1;
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_7cycles got=%b exp=0", stall_timeout); end
    next(); stallreq_from_ex = 1'b1;
    for (int i = 0; i < 7; i++) next();
    #1;
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_cleared got=%b exp=0", stall_timeout); end
    next(); stallreq_from_ex = 1'b0; #1;
    checks++; if (stall_timeout !== 1'b1) begin failures++; $display("FAIL wd_8cycles got=%b exp=1", stall_timeout); end
    next(); next(); #1;
    checks++; if (stall_timeout !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b exp=1", stall_timeout); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    excepttype_i = 32'h00000008; next();
    excepttype_i = 32'h0; stallreq_from_ex = 1'b1; #2;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL pre_reset_flush got=%b exp=1", flush); end
    rst = 1'b0; #1;
    checks++; if (flush !== 1'b0 || stall !== 6'b000000 || new_pc !== 32'h0) begin failures++; $display("FAIL async_reset flush=%b stall=%b pc=%h exp=0/000000/0", flush, stall, new_pc); end
    next(); #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_hold_flush got=%b exp=0", flush); end
    #2 rst = 1'b1;
    next(); clear_inputs(); excepttype_i = 32'h00000008; #1;
    checks++; if (stall !== 6'b011111 || flush !== 1'b0) begin failures++; $display("FAIL post_reset_run stall=%b flush=%b exp=011111/0", stall, flush); end
    next(); excepttype_i = 32'h0; #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h00000020) begin failures++; $display("FAIL post_reset_flush flush=%b pc=%h exp=1/00000020", flush, new_pc); end
    next(); next();
  endtask

  task automatic test_perf();
    logic [31:0] exp_sc, exp_fc;
`ifdef PIPE_CTRL_PERF_EN
    exp_sc = 32'd7;
    exp_fc = 32'd2;
`else
    exp_sc = 32'd0;
    exp_fc = 32'd0;
`endif
    do_reset();
    stallreq_from_ex = 1'b1;
    for (int i = 0; i < 5; i++) next();
    stallreq_from_ex = 1'b0;
    for (int k = 0; k < 2; k++) begin
      excepttype_i = 32'h00000008; next();
      excepttype_i = 32'h0; next();
      next();
    end
    #1;
    checks++; if (stall_cycles !== exp_sc) begin failures++; $display("FAIL perf_stall_cycles got=%0d exp=%0d", stall_cycles, exp_sc); end
    checks++; if (flush_count !== exp_fc) begin failures++; $display("FAIL perf_flush_count got=%0d exp=%0d", flush_count, exp_fc); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_exc_bus_wait();
    test_eret();
    test_watchdog();
    test_reset_mid_flush();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 6-stage pipeline (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the 6-bit stall vector that every pipeline register (if_id, id_ex, ex_mem, mem_wb, pc_reg) consumes.
- Sequences exception/eret flushes through a small FSM and supplies the redirect PC.
- Runs a stall watchdog that flags runaway multicycle stalls (div, madd/msub, bus wait).

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for all exceptions other than eret.
- TIMEOUT, 16'd1024, count of consecutive stalled RUN cycles that sets the watchdog flag; legal range 2..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low: state resets immediately when rst==0, independent of clk.
- stallreq_from_if  in  1  fetch bus wait.
- stallreq_from_id  in  1  load-use hazard.
- stallreq_from_ex  in  1  multicycle ex op (div, madd/msub).
- stallreq_from_mem  in  1  data bus wait.
- excepttype_i  in  32  exception type from the mem stage; 0 means none.
- cp0_epc_i  in  32  current CP0 EPC.
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 means stop.
- flush  out  1  clears all pipeline registers.
- new_pc  out  32  redirect target; valid when flush==1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  32  perf counter, only with the optional feature.
- flush_count  out  32  perf counter, only with the optional feature.

Behaviour:
- Reset values:
  - state=RUN, stall=0, flush=0, new_pc=0.
  - epc_q=0, wd_cnt=0, stall_timeout=0, perf counters=0.
- Stall vector in RUN is combinational, same cycle as the requests. First matching condition wins:
  - exc_det: 6'b011111.
  - mem request: 6'b011111.
  - ex request: 6'b001111.
  - id request or if request: 6'b000111.
  - none: 6'b000000.
- exc_det = (state==RUN) && (excepttype_i!=0) && !stallreq_from_mem.
  - An exception is never taken while the data bus is mid-transfer.
  - It is taken in the first cycle the bus wait drops.
- Redirect target selection:
  - excepttype_i==32'h0000000e (eret): target = cp0_epc_i.
  - Any other nonzero value: target = EXC_VECTOR.
- On exc_det, the selected target is registered into epc_q.
- FSM (registered):
  - RUN -> FLUSH when exc_det; otherwise stay in RUN.
  - FLUSH, exactly 1 cycle: flush=1, new_pc=epc_q, stall=0, all stall requests ignored. Next state SETTLE.
  - SETTLE, exactly 1 cycle: flush=0, new_pc=0. Stall vector follows the requests as in RUN, but exc_det is masked because a bubble is in mem. Next state RUN.
- Exception-to-redirect latency: exc_det in cycle N, flush=1 in cycle N+1, exception detection re-enabled in cycle N+3.
- Outside FLUSH: flush=0 and new_pc=0.
- Watchdog:
  - wd_cnt increments each RUN/SETTLE cycle with stall!=0.
  - It clears to 0 on any cycle with stall==0 and in FLUSH.
  - It saturates at TIMEOUT.
  - stall_timeout is set when wd_cnt==TIMEOUT-1 and stall is still !=0; it then stays 1 until reset.
- Simultaneous events:
  - exc_det in the same cycle as ex/id/if requests: exc_det wins, stall=6'b011111.
  - eret and interrupt never coexist because excepttype_i is already prioritised by the mem stage.
- Reset mid-operation (rst dropping in FLUSH or SETTLE): immediate return to RUN with all outputs 0; no flush pulse is completed.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments every cycle with stall[0]==1.
  - flush_count increments on every FLUSH-state cycle.
  - Both are 32-bit and wrap from 32'hFFFFFFFF to 0.
  - Both reset to 0.
- Undefined: both outputs are tied to 32'h0 and no counter flops are built.

Test Plan:
- Concurrent requests: after reset, assert stallreq_from_ex=1 and stallreq_from_id=1 together -> stall==6'b001111 in the same cycle; drop both -> stall==6'b000000.
- Exception behind a bus wait: excepttype_i=32'h00000008 with stallreq_from_mem=1 for 3 cycles, then mem request drops -> stall==6'b011111 for those 3 cycles and no flush; on the next cycle exc_det fires; one cycle later flush==1 for exactly one cycle with new_pc==32'h00000020.
- eret redirect: excepttype_i=32'h0000000e with cp0_epc_i=32'hBFC00100 -> flush==1 in cycle N+1 with new_pc==32'hBFC00100; an exception re-asserted in cycle N+2 is ignored; the same exception held into cycle N+3 is taken.
- Watchdog: TIMEOUT=8, hold stallreq_from_ex=1 for 7 cycles -> stall_timeout stays 0; hold it for 8 cycles -> stall_timeout==1, and it stays 1 after the request drops.
- Reset mid-sequence: drop rst to 0 asynchronously mid-cycle while in FLUSH -> flush, stall and new_pc go to 0 immediately; after release the FSM is in RUN.
- Perf counters (PIPE_CTRL_PERF_EN defined): 5 stalled cycles and 2 exceptions -> stall_cycles==5 (plus any exc_det cycles) and flush_count==2. Without the macro, both outputs read 0.
